// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: decode-side inputs, forwarding paths and execute-side outputs of the operand stage
//   master : the decode/pipeline side that drives operands, controls, forwarding and out_ready
//   slave  : the operand stage, which returns in_ready, out_valid and the registered operands
interface alu_operand_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [1:0]  op_a_sel;
    logic [1:0]  op_b_sel;
    logic [2:0]  func_in;
    logic        sub_sra_in;
    logic        ex_fwd_en;
    logic        ex_fwd_is_load;
    logic [4:0]  ex_fwd_rd;
    logic [31:0] ex_fwd_data;
    logic        wb_fwd_en;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] store_data;
    logic [2:0]  FUNC;
    logic        sub_sra;
    logic [4:0]  rd_out;

    modport master (
        output in_valid, rs1_data, rs2_data, imm, pc, rs1_addr, rs2_addr, rd_addr,
               op_a_sel, op_b_sel, func_in, sub_sra_in, ex_fwd_en, ex_fwd_is_load,
               ex_fwd_rd, ex_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data, flush, out_ready,
        input  in_ready, out_valid, A, B, store_data, FUNC, sub_sra, rd_out
    );

    modport slave (
        input  in_valid, rs1_data, rs2_data, imm, pc, rs1_addr, rs2_addr, rd_addr,
               op_a_sel, op_b_sel, func_in, sub_sra_in, ex_fwd_en, ex_fwd_is_load,
               ex_fwd_rd, ex_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data, flush, out_ready,
        output in_ready, out_valid, A, B, store_data, FUNC, sub_sra, rd_out
    );
endinterface

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: forwards and selects ALU operands, detects load-use hazards, registers one instruction
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave view of alu_operand_stage_if (decode handshake, forwarding inputs, execute handshake and outputs)
module alu_operand_stage (
    input  logic                clk,
    input  logic                rst_n,
    alu_operand_stage_if.slave  bus
);
    logic        r_valid;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_store;
    logic [2:0]  r_func;
    logic        r_sub_sra;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic        r_a_rs1;
    logic        r_b_rs2;

    logic        w_ex1;
    logic        w_ex2;
    logic        w_wb1;
    logic        w_wb2;
    logic [31:0] w_src1;
    logic [31:0] w_src2;
    logic        w_hazard;
    logic        w_ready;
    logic        w_take;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_snoop1;
    logic        w_snoop2;

    assign w_ex1  = bus.ex_fwd_en && bus.ex_fwd_rd == bus.rs1_addr && bus.rs1_addr != 5'd0;
    assign w_ex2  = bus.ex_fwd_en && bus.ex_fwd_rd == bus.rs2_addr && bus.rs2_addr != 5'd0;
    assign w_wb1  = bus.wb_fwd_en && bus.wb_fwd_rd == bus.rs1_addr && bus.rs1_addr != 5'd0;
    assign w_wb2  = bus.wb_fwd_en && bus.wb_fwd_rd == bus.rs2_addr && bus.rs2_addr != 5'd0;
    assign w_src1 = bus.rs1_addr == 5'd0 ? 32'd0 : w_ex1 ? bus.ex_fwd_data : w_wb1 ? bus.wb_fwd_data : bus.rs1_data;
    assign w_src2 = bus.rs2_addr == 5'd0 ? 32'd0 : w_ex2 ? bus.ex_fwd_data : w_wb2 ? bus.wb_fwd_data : bus.rs2_data;

    // rs2 always feeds store_data, so any EX-load match on rs2 stalls
    assign w_hazard = bus.in_valid && bus.ex_fwd_is_load && ((bus.op_a_sel == 2'b00 && w_ex1) || w_ex2);
    assign w_ready  = (!r_valid || bus.out_ready) && !w_hazard && !bus.flush;
    assign w_take   = bus.in_valid && w_ready;

    assign w_a = bus.op_a_sel == 2'b00 ? w_src1 : bus.op_a_sel == 2'b01 ? bus.pc : 32'd0;
    assign w_b = bus.op_b_sel == 2'b00 ? w_src2 : bus.op_b_sel == 2'b01 ? bus.imm :
                 bus.op_b_sel == 2'b10 ? 32'd4 : 32'd0;

    // a held instruction keeps watching writeback so a value retired during the stall is not lost
    assign w_snoop1 = bus.wb_fwd_en && bus.wb_fwd_rd == r_rs1 && r_rs1 != 5'd0 && r_a_rs1;
    assign w_snoop2 = bus.wb_fwd_en && bus.wb_fwd_rd == r_rs2 && r_rs2 != 5'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_store   <= 32'd0;
            r_func    <= 3'd0;
            r_sub_sra <= 1'b0;
            r_rd      <= 5'd0;
            r_rs1     <= 5'd0;
            r_rs2     <= 5'd0;
            r_a_rs1   <= 1'b0;
            r_b_rs2   <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_take) begin
            r_valid   <= 1'b1;
            r_a       <= w_a;
            r_b       <= w_b;
            r_store   <= w_src2;
            r_func    <= bus.func_in;
            r_sub_sra <= bus.sub_sra_in;
            r_rd      <= bus.rd_addr;
            r_rs1     <= bus.rs1_addr;
            r_rs2     <= bus.rs2_addr;
            r_a_rs1   <= bus.op_a_sel == 2'b00;
            r_b_rs2   <= bus.op_b_sel == 2'b00;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end else if (r_valid) begin
            if (w_snoop1) r_a <= bus.wb_fwd_data;
            if (w_snoop2 && r_b_rs2) r_b <= bus.wb_fwd_data;
            if (w_snoop2) r_store <= bus.wb_fwd_data;
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.out_valid  = r_valid;
    assign bus.A          = r_a;
    assign bus.B          = r_b;
    assign bus.store_data = r_store;
    assign bus.FUNC       = r_func;
    assign bus.sub_sra    = r_sub_sra;
    assign bus.rd_out     = r_rd;
endmodule
